// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch time base and BCD digit generator: counts SS.CC (00.00-59.99)
// under run/stop/clear control and feeds the FND digit-select mux.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   run_toggle in   one-cycle pulse, toggles run/stop
//   clear      in   one-cycle pulse, zeroes the count while stopped
//   digit0     out  centisecond units (BCD 0-9), mux input 0
//   digit1     out  centisecond tens  (BCD 0-9), mux input 1
//   digit2     out  second units      (BCD 0-9), mux input 2
//   digit3     out  second tens       (BCD 0-5), mux input 3
//   running    out  high while in RUN
//   wrap       out  one-cycle pulse after 59.99 -> 00.00
module stopwatch_bcd_counter #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_toggle,
  input  logic       clear,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       wrap
);

  // DIV must be >= 2 for the prescaler to make sense.
  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_CLR  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic [3:0]    r_d0, r_d1, r_d2, r_d3;
  logic [3:0]    w_d0_nxt, w_d1_nxt, w_d2_nxt, w_d3_nxt;
  logic          r_running;
  logic          r_wrap;
  logic          w_tick;
  logic          w_c0, w_c1, w_c2;
  logic          w_rollover;

  // Next-state logic; clear wins over run_toggle when both arrive in STOP.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STOP: begin
        if (clear)           w_state_nxt = ST_CLR;
        else if (run_toggle) w_state_nxt = ST_RUN;
      end
      ST_RUN:  if (run_toggle) w_state_nxt = ST_STOP;
      ST_CLR:  w_state_nxt = ST_STOP;
      default: w_state_nxt = ST_STOP;
    endcase
  end

  // Centisecond tick and BCD carry chain.
  assign w_tick     = (r_state == ST_RUN) && (r_presc == TERM);
  assign w_c0       = w_tick && (r_d0 == 4'd9);
  assign w_c1       = w_c0 && (r_d1 == 4'd9);
  assign w_c2       = w_c1 && (r_d2 == 4'd9);
  assign w_rollover = w_c2 && (r_d3 == 4'd5);

  // Prescaler and digit next values; prescaler holds outside RUN so a
  // partial centisecond survives stop/resume.
  always_comb begin
    w_presc_nxt = r_presc;
    w_d0_nxt    = r_d0;
    w_d1_nxt    = r_d1;
    w_d2_nxt    = r_d2;
    w_d3_nxt    = r_d3;
    if (r_state == ST_CLR) begin
      w_presc_nxt = '0;
      w_d0_nxt    = 4'd0;
      w_d1_nxt    = 4'd0;
      w_d2_nxt    = 4'd0;
      w_d3_nxt    = 4'd0;
    end else if (r_state == ST_RUN) begin
      w_presc_nxt = (r_presc == TERM) ? '0 : r_presc + PW'(1);
      if (w_tick) w_d0_nxt = (r_d0 == 4'd9) ? 4'd0 : r_d0 + 4'd1;
      if (w_c0)   w_d1_nxt = (r_d1 == 4'd9) ? 4'd0 : r_d1 + 4'd1;
      if (w_c1)   w_d2_nxt = (r_d2 == 4'd9) ? 4'd0 : r_d2 + 4'd1;
      if (w_c2)   w_d3_nxt = (r_d3 == 4'd5) ? 4'd0 : r_d3 + 4'd1;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_STOP;
      r_presc   <= '0;
      r_d0      <= 4'd0;
      r_d1      <= 4'd0;
      r_d2      <= 4'd0;
      r_d3      <= 4'd0;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_d0      <= w_d0_nxt;
      r_d1      <= w_d1_nxt;
      r_d2      <= w_d2_nxt;
      r_d3      <= w_d3_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_wrap    <= w_rollover;
    end
  end

  assign digit0  = r_d0;
  assign digit1  = r_d1;
  assign digit2  = r_d2;
  assign digit3  = r_d3;
  assign running = r_running;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Self-checking bench for stopwatch_bcd_counter with CLK_HZ=1000,
// TICK_HZ=100 (DIV=10). Inputs change and outputs are sampled on negedge.
module tb_stopwatch_bcd_counter;

  logic       clk;
  logic       reset;
  logic       run_toggle;
  logic       clear;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       running;
  logic       wrap;

  int errors = 0;
  int checks = 0;
  int wrap_cnt = 0;
  int bcd_bad = 0;
  bit mon_en = 1'b0;

  stopwatch_bcd_counter #(
    .CLK_HZ (1000),
    .TICK_HZ(100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run_toggle(run_toggle),
    .clear     (clear),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .running   (running),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background monitors: wrap pulse count and BCD range.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (wrap === 1'b1) wrap_cnt++;
      if (digit0 > 4'd9 || digit1 > 4'd9 || digit2 > 4'd9 || digit3 > 4'd5)
        bcd_bad++;
    end
  end

  typedef struct {
    logic        rt;
    logic        cl;
    int unsigned n;
    logic [15:0] exp_d;
    logic        exp_run;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [15:0] exp_d,
                       input logic exp_run, input logic exp_wrap);
    logic [15:0] got;
    got = {digit3, digit2, digit1, digit0};
    checks++;
    if (got !== exp_d || running !== exp_run || wrap !== exp_wrap) begin
      errors++;
      $display("FAIL %s: got digits=%h running=%b wrap=%b, expected digits=%h running=%b wrap=%b",
               name, got, running, wrap, exp_d, exp_run, exp_wrap);
    end
  endtask

  // Called at a negedge: drive inputs for one edge, then idle n cycles.
  task automatic apply(input logic rt, input logic cl, input int unsigned n);
    run_toggle = rt;
    clear      = cl;
    @(negedge clk);
    run_toggle = 1'b0;
    clear      = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // {run_toggle, clear, idle cycles after the pulse edge, SS.CC, running}
    vecs[0]  = '{1'b1, 1'b0, 0,   16'h0000, 1'b1}; // start: running next cycle
    vecs[1]  = '{1'b0, 1'b0, 8,   16'h0000, 1'b1}; // 9 run edges, no tick yet
    vecs[2]  = '{1'b0, 1'b0, 0,   16'h0001, 1'b1}; // 10th edge ticks
    vecs[3]  = '{1'b0, 1'b0, 109, 16'h0012, 1'b1}; // 120 edges -> 00.12
    vecs[4]  = '{1'b0, 1'b1, 9,   16'h0013, 1'b1}; // clear ignored in RUN
    vecs[5]  = '{1'b1, 1'b0, 0,   16'h0013, 1'b0}; // stop
    vecs[6]  = '{1'b0, 1'b0, 99,  16'h0013, 1'b0}; // hold while stopped
    vecs[7]  = '{1'b0, 1'b1, 1,   16'h0000, 1'b0}; // clear in STOP
    vecs[8]  = '{1'b1, 1'b0, 24,  16'h0002, 1'b1}; // 24 run edges
    vecs[9]  = '{1'b1, 1'b0, 0,   16'h0002, 1'b0}; // stop with prescaler 5
    vecs[10] = '{1'b0, 1'b0, 99,  16'h0002, 1'b0}; // hold
    vecs[11] = '{1'b1, 1'b0, 4,   16'h0002, 1'b1}; // resume, 4 edges: no tick
    vecs[12] = '{1'b0, 1'b0, 0,   16'h0003, 1'b1}; // 5th edge ticks
    vecs[13] = '{1'b1, 1'b0, 0,   16'h0003, 1'b0}; // stop
    vecs[14] = '{1'b1, 1'b1, 1,   16'h0000, 1'b0}; // toggle+clear: cleared
    vecs[15] = '{1'b0, 1'b0, 4,   16'h0000, 1'b0}; // toggle dropped, still stopped
    vecs[16] = '{1'b1, 1'b0, 9,   16'h0000, 1'b1}; // run to prescaler 9
    vecs[17] = '{1'b1, 1'b0, 0,   16'h0001, 1'b0}; // tick and stop same edge
    vecs[18] = '{1'b0, 1'b1, 1,   16'h0000, 1'b0}; // clear

    reset      = 1'b0;
    run_toggle = 1'b0;
    clear      = 1'b0;

    // Async reset mid-cycle, then held for 50 cycles.
    #3 reset = 1'b1;
    #1 check("reset_async", 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check($sformatf("reset_hold%0d", i), 16'h0000, 1'b0, 1'b0);
    end
    reset  = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].rt, vecs[i].cl, vecs[i].n);
      check($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_run, 1'b0);
    end

    // Rollover: 6000 ticks from 00.00.
    apply(1'b1, 1'b0, 0);
    check("roll_start", 16'h0000, 1'b1, 1'b0);
    repeat (37480) @(negedge clk);
    check("roll_3748", 16'h3748, 1'b1, 1'b0);
    repeat (22510) @(negedge clk);
    check("roll_5999", 16'h5999, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    check("roll_5999_hold", 16'h5999, 1'b1, 1'b0);
    @(negedge clk);
    check("roll_wrap", 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    check("roll_after", 16'h0000, 1'b1, 1'b0);
    checks++;
    if (wrap_cnt != 1) begin
      errors++;
      $display("FAIL wrap_count: got %0d wrap cycles, expected 1", wrap_cnt);
    end
    repeat (29) @(negedge clk);
    check("post_wrap_count", 16'h0003, 1'b1, 1'b0);

    // Reset mid-operation, between clock edges.
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("reset_midop", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apply(1'b1, 1'b0, 9);
    check("restart_no_tick", 16'h0000, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 0);
    check("restart_first_tick", 16'h0001, 1'b1, 1'b0);

    checks++;
    if (bcd_bad != 0) begin
      errors++;
      $display("FAIL bcd_range: got %0d out-of-range samples, expected 0", bcd_bad);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
